// File: rtl/abs.sv
// Registered absolute value: z holds the unsigned magnitude of the two's-complement
// operand a, one clock after a is sampled.
module abs #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] z
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] mag;

   // The most-negative code negates to itself, which read unsigned is 2^(WIDTH-1),
   // the correct magnitude, so no saturation is needed.
   always_comb begin
      mag = a;
      if (a[WIDTH-1]) begin
         mag = ~a + ONE;
      end
   end

   // NOTE: registers are written with non-blocking assignments so every flop
   // samples its inputs as they were before the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         z <= '0;
      end else begin
         z <= mag;
      end
   end

endmodule

// File: tb/tb_abs.sv
// Self-checking bench for abs: directed vector table, hold/no-comb-path sequence,
// and a random sweep against a reference magnitude model.
module tb_abs;

   localparam int WIDTH = 32;

   typedef struct {
      logic             rst;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] z_exp;
   } vec_t;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] z;

   int checks   = 0;
   int failures = 0;

   abs #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .z   (z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [WIDTH-1:0] act,
                        input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: z=%h expected=%h", name, act, exp);
      end
   endtask

   // Drive inputs away from the edge, then sample just after the next rising edge.
   task automatic step(input logic rst_v, input logic [WIDTH-1:0] a_v);
      @(negedge clk);
      rst = rst_v;
      a   = a_v;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WIDTH-1:0] ref_abs(input logic [WIDTH-1:0] v);
      logic signed [WIDTH:0] s;
      s = {v[WIDTH-1], v};
      if (s < 0) s = -s;
      return s[WIDTH-1:0];
   endfunction

   vec_t vecs[$];

   initial begin
      logic [WIDTH-1:0] r;

      rst = 1'b1;
      a   = '0;

      // Consecutive edges; each entry's expectation is z right after its own edge.
      vecs.push_back('{1'b1, 32'hFFFF_FFFF, 32'h0000_0000}); // reset wins over a=-1
      vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'h0000_0001}); // first edge out of reset
      vecs.push_back('{1'b0, 32'h0000_0005, 32'h0000_0005});
      vecs.push_back('{1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF});
      vecs.push_back('{1'b0, 32'hFFFF_FFFB, 32'h0000_0005});
      vecs.push_back('{1'b0, 32'h0000_0000, 32'h0000_0000});
      vecs.push_back('{1'b0, 32'h8000_0000, 32'h8000_0000}); // most negative
      vecs.push_back('{1'b0, 32'h0000_0003, 32'h0000_0003}); // stream 3,-7,0,-(2^31-1)
      vecs.push_back('{1'b0, 32'hFFFF_FFF9, 32'h0000_0007});
      vecs.push_back('{1'b0, 32'h0000_0000, 32'h0000_0000});
      vecs.push_back('{1'b0, 32'h8000_0001, 32'h7FFF_FFFF});
      vecs.push_back('{1'b1, 32'h1234_5678, 32'h0000_0000}); // mid-stream reset pulse
      vecs.push_back('{1'b0, 32'hFFFF_FFFE, 32'h0000_0002}); // one cycle only
      vecs.push_back('{1'b0, 32'h0000_0001, 32'h0000_0001});

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].a);
         check($sformatf("vec%0d a=%h rst=%b", i, vecs[i].a, vecs[i].rst),
               z, vecs[i].z_exp);
      end

      // Hold and no combinational path: changing a mid-cycle must not move z.
      step(1'b0, 32'h0000_0009);
      check("hold_load", z, 32'h0000_0009);
      a = 32'hFFFF_FFFC;
      #2;
      check("hold_no_comb", z, 32'h0000_0009);
      @(posedge clk);
      #1;
      check("hold_next_edge", z, 32'h0000_0004);

      // Reset held for several edges keeps z at zero regardless of a.
      step(1'b1, 32'h8000_0000);
      check("rst_hold0", z, 32'h0000_0000);
      step(1'b1, 32'h7FFF_FFFF);
      check("rst_hold1", z, 32'h0000_0000);
      step(1'b0, 32'h8000_0000);
      check("rst_release_minneg", z, 32'h8000_0000);

      for (int i = 0; i < 5000; i++) begin
         r = $urandom;
         step(1'b0, r);
         check($sformatf("rand%0d a=%h", i, r), z, ref_abs(r));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/abs.md
ABS -- requirements
Module: abs

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; legal values 2..64.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high, sampled on rising edge of clk.
REQ-004 a  input  WIDTH  operand, two's-complement signed.
REQ-005 z  output  WIDTH  absolute value of a, unsigned magnitude, driven directly from a register.
REQ-006 Port order SHALL be clk, rst, a, z; no other ports.

Function
REQ-007 On each rising clk edge with rst low, z SHALL load |a| computed from the value of a sampled at that edge.
REQ-008 Latency SHALL be exactly 1 clock: a sampled at edge k appears on z after edge k and holds until edge k+1.
REQ-009 Throughput SHALL be one new operand per clock, no stalls, no handshake.
REQ-010 a[WIDTH-1]=0: z SHALL equal a unchanged.
REQ-011 a[WIDTH-1]=1: z SHALL equal (~a)+1 modulo 2^WIDTH, i.e. the two's-complement negation.
REQ-012 Most-negative input (1 followed by WIDTH-1 zeros) SHALL yield z of the same bit pattern; read unsigned, this is 2^(WIDTH-1), the correct magnitude, so no saturation or overflow flag.
REQ-013 z SHALL be interpreted as unsigned; full range 0..2^(WIDTH-1) is covered with no loss.
REQ-014 Negation SHALL be purely combinational between the a sample and the z register; no internal pipeline stages beyond the output register.
REQ-015 Behaviour SHALL be fully determined for all 2^WIDTH input codes; X/Z on a need not be handled.
REQ-016 There SHALL be no latches and no combinational path from a to z.

Reset
REQ-017 While rst is high at a rising clk edge, z SHALL load all zeros regardless of a.
REQ-018 On the first rising edge with rst low, z SHALL load |a| of that edge; no extra recovery cycles.
REQ-019 Reset asserted mid-stream SHALL discard the in-flight result; z reads 0 the cycle after the reset edge.
REQ-020 Power-up value of z before the first reset edge is undefined; the bench SHALL apply rst for at least 1 cycle before checking.

Verification
REQ-021 Positive: a=5 -> z=5 one cycle later; a=0x7FFFFFFF -> z=0x7FFFFFFF.
REQ-022 Negative: a=0xFFFFFFFB (-5) -> z=5; a=0xFFFFFFFF (-1) -> z=1.
REQ-023 Boundaries: a=0 -> z=0; a=0x80000000 -> z=0x80000000 (2147483648 unsigned).
REQ-024 Back-to-back stream 3, -7, 0, -2147483647 on consecutive edges -> z sequence 3, 7, 0, 2147483647, one per cycle, 1-cycle lag.
REQ-025 Reset: rst=1 with a=-1 -> z=0; next edge rst=0, a=-1 -> z=1; rst pulsed mid-stream -> z=0 for that cycle only.
REQ-026 Randomized: 5000 random a values, z SHALL match a reference |a| model (unsigned WIDTH-bit result) with 1-cycle alignment, zero mismatches.
